// File: rtl/adv_iir_lp.sv
// adv_iir_lp: parametrised first-order look-ahead IIR low-pass filter
// with shadow coefficients, history clear, and a per-sample overflow flag.
module adv_iir_lp #(
    parameter int W   = 10,
    parameter int CW  = 10,
    parameter bit SAT = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 VIN,
    input  logic signed [W-1:0]  X,
    input  logic signed [CW-1:0] B0,
    input  logic signed [CW-1:0] B1,
    input  logic signed [CW-1:0] A1,
    input  logic signed [CW-1:0] A1_2,
    input  logic                 COEF_LD,
    input  logic                 CLR,
    output logic signed [W-1:0]  Y,
    output logic                 VOUT,
    output logic                 OVF
);
    localparam int S = W + CW + 2;

    logic signed [CW-1:0] b0, b1, a1, a1_2;
    logic signed [W-1:0]  x1, w1, y1, y2, w_n, y_n;
    logic signed [S-1:0]  w_acc, y_acc;
    logic                 w_ovf, y_ovf;

    // Scale back by 2^(CW-1), then clamp or wrap to W bits; MSB flags a misfit.
    function automatic logic [W:0] reduce(input logic signed [S-1:0] s);
        logic signed [S-1:0] t;
        logic                fits;
        logic [W-1:0]        lim;
        t    = s >>> (CW - 1);
        fits = (&t[S-1:W-1]) | ~(|t[S-1:W-1]);
        lim  = t[S-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        return {~fits, (!fits && SAT) ? lim : t[W-1:0]};
    endfunction

    assign w_acc = S'(b0) * S'(X) + S'(b1) * S'(x1);
    assign {w_ovf, w_n} = reduce(w_acc);
    assign y_acc = (S'(w_n) <<< (CW - 1)) - S'(a1) * S'(w1) + S'(a1_2) * S'(y2);
    assign {y_ovf, y_n} = reduce(y_acc);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            {b0, b1, a1, a1_2} <= '0;
            {x1, w1, y1, y2}   <= '0;
            Y                  <= '0;
            VOUT               <= 1'b0;
            OVF                <= 1'b0;
        end else begin
            if (COEF_LD) begin
                b0   <= B0;
                b1   <= B1;
                a1   <= A1;
                a1_2 <= A1_2;
            end
            if (CLR) begin
                {x1, w1, y1, y2} <= '0;
                Y                <= '0;
                VOUT             <= 1'b0;
                OVF              <= 1'b0;
            end else if (VIN) begin
                Y    <= y_n;
                x1   <= X;
                w1   <= w_n;
                y2   <= y1;
                y1   <= y_n;
                VOUT <= 1'b1;
                OVF  <= w_ovf | y_ovf;
            end else begin
                VOUT <= 1'b0;
                OVF  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_adv_iir_lp.sv
// tb_adv_iir_lp: directed scenarios plus random stimulus against an
// arithmetic reference model, for saturating and wrapping builds together.
module tb_adv_iir_lp;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vin = 1'b0, coef_ld = 1'b0, clr = 1'b0;
    logic signed [9:0] x = '0, b0 = '0, b1 = '0, a1 = '0, a12 = '0;
    logic signed [9:0] y_s, y_w;
    logic v_s, v_w, o_s, o_w;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    adv_iir_lp #(.W(10), .CW(10), .SAT(1'b1)) u_sat (
        .CLK(clk), .RST_N(rst_n), .VIN(vin), .X(x), .B0(b0), .B1(b1), .A1(a1), .A1_2(a12),
        .COEF_LD(coef_ld), .CLR(clr), .Y(y_s), .VOUT(v_s), .OVF(o_s));
    adv_iir_lp #(.W(10), .CW(10), .SAT(1'b0)) u_wrap (
        .CLK(clk), .RST_N(rst_n), .VIN(vin), .X(x), .B0(b0), .B1(b1), .A1(a1), .A1_2(a12),
        .COEF_LD(coef_ld), .CLR(clr), .Y(y_w), .VOUT(v_w), .OVF(o_w));

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic, floor shift, then clamp or wrap.
    function automatic int qm(input longint s, input bit sat, output bit o);
        longint t;
        t = s >>> 9;
        o = (t > 511) || (t < -512);
        if (!o) return int'(t);
        if (sat) return (t > 0) ? 511 : -512;
        return int'(((t % 1024) + 1536) % 1024) - 512;
    endfunction

    int mb0 = 0, mb1 = 0, ma1 = 0, ma12 = 0, mx1 = 0, mv = 0;
    int mw1[2] = '{0, 0}, my1[2] = '{0, 0}, my2[2] = '{0, 0}, my[2] = '{0, 0}, mo[2] = '{0, 0};

    always @(posedge clk or negedge rst_n) begin
        int wn, yn;
        bit ow, oy;
        longint s;
        if (!rst_n) begin
            {mb0, mb1, ma1, ma12, mx1, mv} = '0;
            for (int m = 0; m < 2; m++) {mw1[m], my1[m], my2[m], my[m], mo[m]} = '0;
        end else begin
            if (clr) begin
                mx1 = 0; mv = 0;
                for (int m = 0; m < 2; m++) {mw1[m], my1[m], my2[m], my[m], mo[m]} = '0;
            end else if (vin) begin
                for (int m = 0; m < 2; m++) begin
                    s  = longint'(mb0) * longint'(x) + longint'(mb1) * longint'(mx1);
                    wn = qm(s, m == 0, ow);
                    s  = longint'(wn) * 512 - longint'(ma1) * mw1[m] + longint'(ma12) * my2[m];
                    yn = qm(s, m == 0, oy);
                    my[m] = yn; mo[m] = int'(ow | oy);
                    mw1[m] = wn; my2[m] = my1[m]; my1[m] = yn;
                end
                mx1 = int'(x); mv = 1;
            end else begin
                mv = 0; mo[0] = 0; mo[1] = 0;
            end
            if (coef_ld) begin
                mb0 = int'(b0); mb1 = int'(b1); ma1 = int'(a1); ma12 = int'(a12);
            end
        end
    end

    always @(negedge clk) begin
        chk("model_y_sat", int'(y_s), my[0]);
        chk("model_y_wrap", int'(y_w), my[1]);
        chk("model_vout_sat", int'(v_s), mv);
        chk("model_vout_wrap", int'(v_w), mv);
        chk("model_ovf_sat", int'(o_s), mo[0]);
        chk("model_ovf_wrap", int'(o_w), mo[1]);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int c0, input int c1, input int c2, input int c3, input bit cl);
        b0 = 10'(c0); b1 = 10'(c1); a1 = 10'(c2); a12 = 10'(c3);
        coef_ld = 1'b1; clr = cl; vin = 1'b0;
        cyc();
        coef_ld = 1'b0; clr = 1'b0;
    endtask

    int exp_imp[5] = '{100, 150, 75, 37, 18};

    initial begin
        #2;
        chk("reset_y", int'(y_s), 0);
        chk("reset_vout", int'(v_s), 0);
        chk("reset_ovf", int'(o_s), 0);
        #1 rst_n = 1'b1;
        // Scenario 1: pass-through at half gain
        load(256, 0, 0, 0, 1'b0);
        vin = 1'b1; x = 10'sd100; cyc();
        chk("s1_y", int'(y_s), 50);
        chk("s1_vout", int'(v_s), 1);
        chk("s1_ovf", int'(o_s), 0);
        vin = 1'b0; cyc();
        chk("s1_idle_vout", int'(v_s), 0);
        chk("s1_idle_y", int'(y_s), 50);
        // Scenario 2: impulse response, back-to-back
        load(256, 256, -256, 128, 1'b1);
        for (int i = 0; i < 5; i++) begin
            vin = 1'b1; x = (i == 0) ? 10'sd200 : 10'sd0; cyc();
            chk("s2_y", int'(y_s), exp_imp[i]);
            chk("s2_vout", int'(v_s), 1);
        end
        // Scenario 3: same impulse with 3 idle cycles between samples
        vin = 1'b0; clr = 1'b1; cyc(); clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vin = 1'b1; x = (i == 0) ? 10'sd200 : 10'sd0; cyc();
            chk("s3_y", int'(y_s), exp_imp[i]);
            chk("s3_vout", int'(v_s), 1);
            vin = 1'b0;
            for (int k = 0; k < 3; k++) begin
                cyc();
                chk("s3_gap_vout", int'(v_s), 0);
                chk("s3_gap_y", int'(y_s), exp_imp[i]);
            end
        end
        // Scenario 5: clear mid-response discards the coincident sample
        clr = 1'b1; cyc(); clr = 1'b0;
        vin = 1'b1; x = 10'sd200; cyc();
        x = 10'sd0; cyc();
        chk("s5_mid_y", int'(y_s), 150);
        clr = 1'b1; x = 10'sd200; cyc(); clr = 1'b0;
        chk("s5_clr_y", int'(y_s), 0);
        chk("s5_clr_vout", int'(v_s), 0);
        x = 10'sd0; cyc();
        chk("s5_after_y", int'(y_s), 0);
        chk("s5_after_vout", int'(v_s), 1);
        // Scenario 4: overflow, saturating versus wrapping
        load(511, 511, 0, 0, 1'b1);
        vin = 1'b1; x = 10'sd511; cyc();
        chk("s4_first_y", int'(y_s), 510);
        chk("s4_first_ovf", int'(o_s), 0);
        cyc();
        chk("s4_sat_y", int'(y_s), 511);
        chk("s4_sat_ovf", int'(o_s), 1);
        chk("s4_wrap_y", int'(y_w), -4);
        chk("s4_wrap_ovf", int'(o_w), 1);
        // Scenario 6: coefficient load coincident with a sample uses old values
        load(0, 0, 0, 0, 1'b1);
        b0 = 10'sd256; coef_ld = 1'b1; vin = 1'b1; x = 10'sd100; cyc();
        coef_ld = 1'b0;
        chk("s6_old_coef_y", int'(y_s), 0);
        cyc();
        chk("s6_new_coef_y", int'(y_s), 50);
        vin = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("s6_async_y", int'(y_s), 0);
        chk("s6_async_vout", int'(v_s), 0);
        chk("s6_async_ovf", int'(o_w), 0);
        #1 rst_n = 1'b1;
        // Random phase
        for (int n = 0; n < 1500; n++) begin
            coef_ld = ($urandom_range(0, 15) == 0);
            b0 = 10'($urandom); b1 = 10'($urandom); a1 = 10'($urandom); a12 = 10'($urandom);
            clr = ($urandom_range(0, 31) == 0);
            vin = ($urandom_range(0, 3) != 0);
            x = 10'($urandom);
            cyc();
        end
        coef_ld = 1'b0; clr = 1'b0; vin = 1'b0;
        cyc();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
